intdiv_seq: RTL and testbench
=============================

# intdiv_seq

Iteration controller for the SD2 (radix-2 signed-digit) integer divider. Sequences the digit-recurrence datapath through N quotient-digit steps, then collects the quotient digits into an SD2 register. Applies the final negative-remainder correction by subtracting one LSD unit, propagating the borrow serially. Sits between the issuing logic (start/done handshake) and the divider datapath (load/step/fix strobes).

## Interface
- N, 8: quotient digits per division (N ≥ 2)
- IW, $clog2(N): width of dp_idx
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a division; sampled only in IDLE
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse, quotient/ovf valid
- dp_load  out  1  one-cycle strobe: datapath loads operands
- dp_step  out  1  datapath performs one recurrence step
- dp_idx  out  IW  digit index of current step/correction position
- q_digit  in  2  SD2 quotient digit from datapath, valid while dp_step=1
- rem_neg  in  1  final partial remainder negative; sampled in FIX
- dp_fix  out  1  one-cycle strobe: datapath adds divisor back to remainder
- quotient  out  2N  SD2 quotient, digit i at [2i+1:2i]
- ovf  out  1  borrow propagated out of MSD during correction

## Operation
- SD2 encoding, (p,n) form from the shared encoding header: POS1=2'b10, NEG1=2'b01, ZERO_1=2'b00, ZERO_2=2'b11; all four codes legal, both zeros equal 0.
- States: IDLE, LOAD, ITER, FIX, CORR, DONE.
- IDLE: start=1 → LOAD; otherwise stay. start is ignored in every other state.
- LOAD: dp_load=1; quotient cleared to all ZERO_1; ovf cleared; counter set to N-1 → ITER.
- ITER: dp_step=1, dp_idx=counter; q_digit written to digit[counter] (MSD first, unchanged code, ZERO_2 kept). Counter decrements; after the idx-0 step → FIX.
- FIX: rem_neg=0 → DONE. rem_neg=1 → dp_fix=1, borrow=1, counter=0 → CORR.
- CORR: one digit per cycle from LSD upward, dp_idx=counter:
  - POS1 → ZERO_1, borrow absorbed → DONE.
  - ZERO_1/ZERO_2 → NEG1, borrow absorbed → DONE.
  - NEG1 → ZERO_1, borrow kept; counter+1. If counter was N-1 → ovf=1 → DONE.
- DONE: done=1 → IDLE. quotient and ovf are held until the next LOAD.
- No arithmetic beyond digit rewrite; counter never wraps (ITER stops at 0, CORR stops at N-1).

## Timing
- Reset (any time, including mid-ITER/CORR): state IDLE; busy, done, dp_load, dp_step, dp_fix, ovf = 0; dp_idx = 0; quotient = all ZERO_1. Operation aborted, no done.
- start sampled at edge E0 → LOAD in cycle 1, ITER in cycles 2..N+1, FIX in cycle N+2.
- No correction: done in cycle N+3. Correction touching k digits (1 ≤ k ≤ N): CORR cycles N+3..N+2+k, done in cycle N+3+k.
- dp_step is continuous for exactly N cycles. dp_fix is exactly 1 cycle, coincident with FIX.
- busy rises the cycle after start is sampled and falls the cycle after done.
- start held high through DONE: the next operation's LOAD follows one IDLE cycle after done.
- quotient digit updates are visible the cycle after the writing state.

## Test plan
- N=4, q_digit POS1,NEG1,ZERO_1,POS1 (MSD first), rem_neg=0 → quotient=8'b10_01_00_10, ovf=0, dp_fix never high, done in cycle 7.
- N=4, q_digit POS1,ZERO_1,NEG1,NEG1, rem_neg=1 → dp_fix in cycle 6, CORR 3 cycles (dp_idx 0,1,2), quotient=8'b10_01_00_00 (5→4), ovf=0, done in cycle 10.
- N=4, all NEG1, rem_neg=1 → CORR 4 cycles, quotient=8'b00_00_00_00, ovf=1, done in cycle 11.
- N=4, q_digit ZERO_2,ZERO_2,POS1,ZERO_2, rem_neg=1 → LSD becomes NEG1, quotient=8'b11_11_10_01, CORR 1 cycle, done in cycle 8.
- rst pulsed in cycle 3 (mid-ITER) → all outputs at reset values next cycle, no done; start pulses during busy ignored; fresh start afterwards completes normally.
- start held high continuously → back-to-back operations, each with dp_load one cycle after an IDLE cycle, quotient cleared on each LOAD.

Source files
------------

// File: rtl/intdiv_seq.sv
// Iteration controller for the SD2 radix-2 signed-digit divider: sequences load,
// N recurrence steps, optional remainder fix and serial LSD-borrow correction.
module intdiv_seq #(
   parameter int N  = 8,
   parameter int IW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic            dp_load,
   output logic            dp_step,
   output logic [IW-1:0]   dp_idx,
   input  logic [1:0]      q_digit,
   input  logic            rem_neg,
   output logic            dp_fix,
   output logic [2*N-1:0]  quotient,
   output logic            ovf
);

   typedef enum logic [2:0] {IDLE, LOAD, ITER, FIX, CORR, DONE} state_t;

   localparam logic [1:0]    POS1   = 2'b10;
   localparam logic [1:0]    NEG1   = 2'b01;
   localparam logic [1:0]    ZERO_1 = 2'b00;
   localparam logic [IW-1:0] LAST   = IW'(N - 1);

   state_t        state;
   logic [IW-1:0] cnt;
   logic [1:0]    digits [N];

   assign dp_idx = cnt;

   // rem_neg is only known during FIX itself, so the fix strobe cannot be registered.
   assign dp_fix = (state == FIX) && rem_neg;

   always_comb begin
      quotient = '0;
      for (int unsigned i = 0; i < N; i++)
         quotient[2*i +: 2] = digits[i];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         dp_load <= 1'b0;
         dp_step <= 1'b0;
         ovf     <= 1'b0;
         cnt     <= '0;
         digits  <= '{default: ZERO_1};
      end else begin
         done    <= 1'b0;
         dp_load <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= LOAD;
                  busy    <= 1'b1;
                  dp_load <= 1'b1;
               end
            end
            LOAD: begin
               digits  <= '{default: ZERO_1};
               ovf     <= 1'b0;
               cnt     <= LAST;
               dp_step <= 1'b1;
               state   <= ITER;
            end
            ITER: begin
               digits[cnt] <= q_digit;
               if (cnt == '0) begin
                  dp_step <= 1'b0;
                  state   <= FIX;
               end else begin
                  cnt <= cnt - IW'(1);
               end
            end
            FIX: begin
               if (rem_neg) begin
                  cnt   <= '0;
                  state <= CORR;
               end else begin
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            CORR: begin
               // Subtract one LSD unit; only a NEG1 digit passes the borrow upward.
               case (digits[cnt])
                  NEG1: begin
                     digits[cnt] <= ZERO_1;
                     if (cnt == LAST) begin
                        ovf   <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                     end else begin
                        cnt <= cnt + IW'(1);
                     end
                  end
                  POS1: begin
                     digits[cnt] <= ZERO_1;
                     done        <= 1'b1;
                     state       <= DONE;
                  end
                  default: begin
                     digits[cnt] <= NEG1;
                     done        <= 1'b1;
                     state       <= DONE;
                  end
               endcase
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               dp_step <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_intdiv_seq.sv
// Cycle-exact bench for intdiv_seq (N=4): directed cases, reset abort, back-to-back
// starts and random operations checked against an arithmetic SD2 reference.
module tb_intdiv_seq;

   localparam int N  = 4;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic            busy, done, dp_load, dp_step, dp_fix, ovf;
   logic [IW-1:0]   dp_idx;
   logic [1:0]      q_digit = 2'b00;
   logic            rem_neg = 1'b0;
   logic [2*N-1:0]  quotient;

   int checks   = 0;
   int failures = 0;

   intdiv_seq #(.N(N), .IW(IW)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .dp_load(dp_load), .dp_step(dp_step), .dp_idx(dp_idx), .q_digit(q_digit),
      .rem_neg(rem_neg), .dp_fix(dp_fix), .quotient(quotient), .ovf(ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Signed integer value of an SD2 digit vector.
   function automatic int sdval(input logic [2*N-1:0] q);
      int v = 0;
      for (int i = N - 1; i >= 0; i--) begin
         v = v * 2;
         if (q[2*i +: 2] == 2'b10) v = v + 1;
         else if (q[2*i +: 2] == 2'b01) v = v - 1;
      end
      return v;
   endfunction

   // Expected digits after subtracting one LSD unit, the overflow flag and digits touched.
   task automatic corr_model(input logic [2*N-1:0] q, output logic [2*N-1:0] r,
                             output logic o, output int k);
      bit found = 0;
      r = q; o = 1'b0; k = N;
      for (int i = 0; i < N; i++) begin
         if (!found) begin
            if (r[2*i +: 2] == 2'b01) r[2*i +: 2] = 2'b00;
            else begin
               r[2*i +: 2] = (r[2*i +: 2] == 2'b10) ? 2'b00 : 2'b01;
               found = 1;
               k = i + 1;
            end
         end
      end
      if (!found) o = 1'b1;
   endtask

   // Entered #1 into an IDLE cycle; returns #1 into the IDLE cycle after done.
   task automatic run_op(input logic [2*N-1:0] qd, input logic rn, input bit hold,
                         input bit noise, input bit use_c, input logic [2*N-1:0] cq,
                         input logic co);
      logic [2*N-1:0] exp_q, partial;
      logic           exp_o;
      int             k;
      if (rn) corr_model(qd, exp_q, exp_o, k);
      else begin exp_q = qd; exp_o = 1'b0; k = 0; end

      start = 1'b1;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      chk("load_strobe", 64'(dp_load), 64'd1);
      chk("load_busy",   64'(busy),    64'd1);
      chk("load_step",   64'(dp_step), 64'd0);
      chk("load_done",   64'(done),    64'd0);

      partial = '0;
      for (int c = 0; c < N; c++) begin
         @(posedge clk); #1;
         if (noise && !hold) start = 1'($urandom_range(0, 1));
         q_digit = qd[2*(N-1-c) +: 2];
         rem_neg = noise ? 1'($urandom_range(0, 1)) : rn;
         #1;
         chk("iter_step", 64'(dp_step),  64'd1);
         chk("iter_idx",  64'(dp_idx),   64'(N - 1 - c));
         chk("iter_load", 64'(dp_load),  64'd0);
         chk("iter_fix",  64'(dp_fix),   64'd0);
         chk("iter_q",    64'(quotient), 64'(partial));
         partial[2*(N-1-c) +: 2] = qd[2*(N-1-c) +: 2];
      end

      @(posedge clk); #1;
      rem_neg = rn;
      q_digit = 2'($urandom);
      #1;
      chk("fix_strobe", 64'(dp_fix),   64'(rn));
      chk("fix_step",   64'(dp_step),  64'd0);
      chk("fix_q",      64'(quotient), 64'(qd));
      chk("fix_busy",   64'(busy),     64'd1);
      chk("fix_done",   64'(done),     64'd0);

      for (int j = 0; j < k; j++) begin
         @(posedge clk); #1;
         if (noise && !hold) start = 1'($urandom_range(0, 1));
         chk("corr_idx",  64'(dp_idx), 64'(j));
         chk("corr_fix",  64'(dp_fix), 64'd0);
         chk("corr_done", 64'(done),   64'd0);
         chk("corr_busy", 64'(busy),   64'd1);
      end

      @(posedge clk); #1;
      start = hold ? 1'b1 : 1'b0;
      chk("done_pulse", 64'(done),     64'd1);
      chk("done_busy",  64'(busy),     64'd1);
      chk("done_q",     64'(quotient), 64'(exp_q));
      chk("done_ovf",   64'(ovf),      64'(exp_o));
      chk("done_value", 64'(sdval(quotient) - (ovf ? (1 << N) : 0)),
                        64'(sdval(qd) - (rn ? 1 : 0)));
      if (use_c) begin
         chk("const_q",   64'(quotient), 64'(cq));
         chk("const_ovf", 64'(ovf),      64'(co));
      end

      @(posedge clk); #1;
      chk("idle_busy", 64'(busy),     64'd0);
      chk("idle_done", 64'(done),     64'd0);
      chk("idle_load", 64'(dp_load),  64'd0);
      chk("idle_q",    64'(quotient), 64'(exp_q));
      chk("idle_ovf",  64'(ovf),      64'(exp_o));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_busy"}, 64'(busy),     64'd0);
      chk({tag, "_done"}, 64'(done),     64'd0);
      chk({tag, "_load"}, 64'(dp_load),  64'd0);
      chk({tag, "_step"}, 64'(dp_step),  64'd0);
      chk({tag, "_fix"},  64'(dp_fix),   64'd0);
      chk({tag, "_ovf"},  64'(ovf),      64'd0);
      chk({tag, "_idx"},  64'(dp_idx),   64'd0);
      chk({tag, "_q"},    64'(quotient), 64'd0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("por");
      rst = 1'b0;
      @(posedge clk); #1;
      chk_reset_vals("idle");

      run_op(8'b10_01_00_10, 1'b0, 0, 0, 1, 8'b10_01_00_10, 1'b0);
      run_op(8'b10_00_01_01, 1'b1, 0, 0, 1, 8'b10_01_00_00, 1'b0);
      run_op(8'b01_01_01_01, 1'b1, 0, 0, 1, 8'b00_00_00_00, 1'b1);
      run_op(8'b11_11_10_11, 1'b1, 0, 0, 1, 8'b11_11_10_01, 1'b0);

      // Abort mid-ITER with an asynchronous reset in cycle 3.
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      q_digit = 2'b10;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk_reset_vals("async_rst");
      @(posedge clk); #1;
      chk_reset_vals("rst_held");
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("post_rst_done", 64'(done), 64'd0);
         chk("post_rst_busy", 64'(busy), 64'd0);
      end

      run_op(8'b10_00_01_01, 1'b1, 0, 1, 1, 8'b10_01_00_00, 1'b0);

      // start held high: each LOAD follows exactly one IDLE cycle.
      for (int i = 0; i < 4; i++)
         run_op(8'($urandom), 1'($urandom_range(0, 1)), 1, 0, 0, '0, 1'b0);
      start = 1'b0;
      @(posedge clk); #1;
      chk("hold_release_busy", 64'(busy), 64'd0);

      for (int i = 0; i < 24; i++)
         run_op(8'($urandom), 1'($urandom_range(0, 1)), 0, 1, 0, '0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
